// File: rtl/seven_seg_pkg.sv
// Shared constants and helpers for the seven-segment display blocks.
package seven_seg_pkg;
  localparam int DIGITS_DEFAULT   = 4;
  localparam int PRESCALE_DEFAULT = 50000;
  localparam int MAX_DIGITS       = 8;

  // All anodes dark; callers slice this down to their own digit count.
  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // One-hot-low anode pattern with the digit at idx lit.
  function automatic logic [MAX_DIGITS-1:0] idx_to_anode(input logic [2:0] idx);
    return ~(MAX_DIGITS'(1) << idx);
  endfunction
endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: tick is high for one cycle out of every PRESCALE.
module scan_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  // Count 0..PRESCALE-1 and wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Scans MSD -> LSD, holds a frame-stable copy of the BCD value and flags
// zeros that sit left of the most significant non-zero digit.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int DIGITS   = DIGITS_DEFAULT,
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*DIGITS-1:0]       value_in,
  input  logic                      load,
  input  logic                      blank_en,
  output logic [3:0]                bcd_out,
  output logic                      leading_zero,
  output logic [DIGITS-1:0]         anode,
  output logic [$clog2(DIGITS)-1:0] digit_idx,
  output logic                      frame_start
);
  localparam int IW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;
  localparam logic [IW-1:0] MSD = IW'(DIGITS - 1);

  logic                  tick;
  logic [IW-1:0]         idx;        // digit currently lit (internal)
  logic                  lit;        // 0 until the first tick after reset
  logic                  zrun;       // all higher digits scanned so far were 0
  logic [VW-1:0]         pending;
  logic [VW-1:0]         shadow;

  logic                  boundary;
  logic [IW-1:0]         enter_idx;
  logic [2:0]            enter_idx3;
  logic [VW-1:0]         shadow_next;
  logic [3:0]            leave_nib;
  logic [3:0]            enter_nib;
  logic                  zrun_next;
  logic [MAX_DIGITS-1:0] anode_full;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-digit selection, frame boundary detection and zero-run tracking.
  always_comb begin
    boundary    = tick & (~lit | (idx == '0));
    enter_idx   = boundary ? MSD : idx - IW'(1);
    enter_idx3  = 3'(enter_idx);
    // A load coinciding with the boundary tick goes straight into the frame.
    shadow_next = boundary ? (load ? value_in : pending) : shadow;
    leave_nib   = shadow[{idx, 2'b00} +: 4];
    enter_nib   = shadow_next[{enter_idx, 2'b00} +: 4];
    // Nibbles above 9 are simply non-zero here.
    zrun_next   = boundary ? 1'b1 : (zrun & (leave_nib == 4'd0));
    anode_full  = idx_to_anode(enter_idx3);
  end

  // Scan state and value registers; shadow only changes at a frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= MSD;
      lit     <= 1'b0;
      zrun    <= 1'b1;
      pending <= '0;
      shadow  <= '0;
    end else begin
      if (load) pending <= value_in;
      if (tick) begin
        idx    <= enter_idx;
        lit    <= 1'b1;
        zrun   <= zrun_next;
        shadow <= shadow_next;
      end
    end
  end

  // Registered display outputs, refreshed on tick only. A digit is in the
  // leading-zero region when it and every higher digit are zero; digit 0
  // is always shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anode        <= ANODE_OFF[DIGITS-1:0];
      bcd_out      <= 4'd0;
      leading_zero <= 1'b0;
      digit_idx    <= '0;
      frame_start  <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (tick) begin
        anode        <= anode_full[DIGITS-1:0];
        bcd_out      <= enter_nib;
        leading_zero <= blank_en & zrun_next & (enter_nib == 4'd0) & (enter_idx != '0);
        digit_idx    <= enter_idx;
      end
    end
  end
endmodule
